// File: rtl/pp_uv_pkg.sv
// Shared definitions for the UV row-duplication stage: parameter defaults and FSM states.
package pp_uv_pkg;
    localparam int PIX_W_DEF    = 16;
    localparam int DIM_W_DEF    = 11;
    localparam int MAX_COLS_DEF = 2048;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PARAM = 3'd1,
        ST_PASS0 = 3'd2,
        ST_PASS1 = 3'd3,
        ST_DONE  = 3'd4
    } state_e;
endpackage

// File: rtl/pp_pipeline_accel_uv_linebuf.sv
// One-row line buffer: simple dual-port RAM with a 1-cycle registered read.
module pp_pipeline_accel_uv_linebuf #(
    parameter int PIX_W = 16,
    parameter int DEPTH = 2048,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [PIX_W-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [PIX_W-1:0] rdata
);
    logic [PIX_W-1:0] mem [DEPTH];
    logic [PIX_W-1:0] rdata_q;

    // rdata holds its value while re is low; the top relies on that as a storage stage.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/pp_pipeline_accel_uv_row_dup.sv
// 4:2:0 -> 4:2:2 chroma upsampler: every UV row is streamed through, then replayed from a line buffer.
module pp_pipeline_accel_uv_row_dup
    import pp_uv_pkg::*;
#(
    parameter int PIX_W    = PIX_W_DEF,
    parameter int DIM_W    = DIM_W_DEF,
    parameter int MAX_COLS = MAX_COLS_DEF
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             ap_start,
    output logic             ap_done,
    output logic             ap_ready,
    output logic             ap_idle,
    input  logic             ap_continue,
    input  logic [DIM_W-1:0] rows_dout,
    input  logic             rows_empty_n,
    output logic             rows_read,
    input  logic [DIM_W-1:0] cols_dout,
    input  logic             cols_empty_n,
    output logic             cols_read,
    input  logic [PIX_W-1:0] uv_in_dout,
    input  logic             uv_in_empty_n,
    output logic             uv_in_read,
    output logic [PIX_W-1:0] uv_out_din,
    input  logic             uv_out_full_n,
    output logic             uv_out_write,
    output state_e           dbg_state
);
    localparam int AW = $clog2(MAX_COLS);

    state_e           state_q, state_d;
    logic [DIM_W-1:0] rows_q, rows_d, cols_q, cols_d;
    logic [DIM_W-1:0] row_q, row_d, col_q, col_d, rd_cnt_q, rd_cnt_d;
    logic             rv_q, rv_d, sv_q, sv_d, ap_ready_q, ap_ready_d;
    logic [PIX_W-1:0] skid_q, skid_d;

    logic             lb_we, lb_re, last_col, last_row, fire, rv_left, sv_left;
    logic [PIX_W-1:0] lb_rdata;

    // Valid/ready: a FIFO pop or push happens exactly in a cycle where the read/write strobe is 1,
    // and a strobe is raised only while the matching empty_n/full_n is 1 in that same cycle.
    pp_pipeline_accel_uv_linebuf #(.PIX_W(PIX_W), .DEPTH(MAX_COLS), .AW(AW)) u_linebuf (
        .clk   (ap_clk),
        .we    (lb_we),
        .waddr (AW'(col_q)),
        .wdata (uv_in_dout),
        .re    (lb_re),
        .raddr (AW'(rd_cnt_q)),
        .rdata (lb_rdata)
    );

    assign last_col = (col_q == cols_q - DIM_W'(1));
    assign last_row = (row_q == rows_q - DIM_W'(1));

    always_comb begin
        state_d      = state_q;
        rows_d       = rows_q;
        cols_d       = cols_q;
        row_d        = row_q;
        col_d        = col_q;
        rd_cnt_d     = rd_cnt_q;
        rv_d         = rv_q;
        sv_d         = sv_q;
        skid_d       = skid_q;
        rows_read    = 1'b0;
        cols_read    = 1'b0;
        uv_in_read   = 1'b0;
        uv_out_write = 1'b0;
        uv_out_din   = '0;
        lb_we        = 1'b0;
        lb_re        = 1'b0;
        fire         = 1'b0;
        rv_left      = 1'b0;
        sv_left      = 1'b0;
        case (state_q)
            ST_IDLE: if (ap_start) state_d = ST_PARAM;
            ST_PARAM: begin
                if (rows_empty_n && cols_empty_n) begin
                    rows_read = 1'b1;
                    cols_read = 1'b1;
                    rows_d    = rows_dout;
                    cols_d    = cols_dout;
                    row_d     = '0;
                    col_d     = '0;
                    rd_cnt_d  = '0;
                    state_d   = (rows_dout == '0 || cols_dout == '0) ? ST_DONE : ST_PASS0;
                end
            end
            ST_PASS0: begin
                uv_out_din = uv_in_dout;
                if (uv_in_empty_n && uv_out_full_n) begin
                    uv_in_read   = 1'b1;
                    uv_out_write = 1'b1;
                    lb_we        = 1'b1;
                    if (last_col) begin
                        col_d    = '0;
                        rd_cnt_d = '0;
                        state_d  = ST_PASS1;
                    end else begin
                        col_d = col_q + DIM_W'(1);
                    end
                end
            end
            ST_PASS1: begin
                // Head of the replay is the skid entry if present, else the RAM output register.
                uv_out_din   = sv_q ? skid_q : lb_rdata;
                fire         = (sv_q || rv_q) && uv_out_full_n;
                uv_out_write = fire;
                rv_left      = rv_q && !(fire && !sv_q);
                sv_left      = sv_q && !fire;
                lb_re        = (rd_cnt_q < cols_q) && !(sv_q && rv_q && !fire);
                if (lb_re) begin
                    // A new read overwrites the RAM output, so an unconsumed word moves to the skid.
                    rd_cnt_d = rd_cnt_q + DIM_W'(1);
                    rv_d     = 1'b1;
                    if (rv_left) begin
                        sv_d   = 1'b1;
                        skid_d = lb_rdata;
                    end else begin
                        sv_d = sv_left;
                    end
                end else begin
                    rv_d = rv_left;
                    sv_d = sv_left;
                end
                if (fire) begin
                    if (last_col) begin
                        col_d = '0;
                        if (last_row) begin
                            state_d = ST_DONE;
                        end else begin
                            row_d   = row_q + DIM_W'(1);
                            state_d = ST_PASS0;
                        end
                    end else begin
                        col_d = col_q + DIM_W'(1);
                    end
                end
            end
            ST_DONE: if (ap_continue) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        ap_ready_d = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= ST_IDLE;
            rows_q     <= '0;
            cols_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            rd_cnt_q   <= '0;
            rv_q       <= 1'b0;
            sv_q       <= 1'b0;
            skid_q     <= '0;
            ap_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rows_q     <= rows_d;
            cols_q     <= cols_d;
            row_q      <= row_d;
            col_q      <= col_d;
            rd_cnt_q   <= rd_cnt_d;
            rv_q       <= rv_d;
            sv_q       <= sv_d;
            skid_q     <= skid_d;
            ap_ready_q <= ap_ready_d;
        end
    end

    assign ap_idle   = (state_q == ST_IDLE);
    assign ap_done   = (state_q == ST_DONE);
    assign ap_ready  = ap_ready_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_pp_pipeline_accel_uv_row_dup.sv
// Directed bench for the UV row duplicator: frame table plus hold and mid-frame reset sequences.
module tb_pp_pipeline_accel_uv_row_dup;
    import pp_uv_pkg::*;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        ap_start = 1'b0, ap_continue = 1'b0;
    logic        ap_done, ap_ready, ap_idle;
    logic [10:0] rows_dout = '0, cols_dout = '0;
    logic        rows_empty_n = 1'b0, cols_empty_n = 1'b0, rows_read, cols_read;
    logic [15:0] uv_in_dout = '0, uv_out_din;
    logic        uv_in_empty_n = 1'b0, uv_in_read;
    logic        uv_out_full_n = 1'b1, uv_out_write;
    state_e      dbg_state;

    pp_pipeline_accel_uv_row_dup dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_done(ap_done),
        .ap_ready(ap_ready), .ap_idle(ap_idle), .ap_continue(ap_continue),
        .rows_dout(rows_dout), .rows_empty_n(rows_empty_n), .rows_read(rows_read),
        .cols_dout(cols_dout), .cols_empty_n(cols_empty_n), .cols_read(cols_read),
        .uv_in_dout(uv_in_dout), .uv_in_empty_n(uv_in_empty_n), .uv_in_read(uv_in_read),
        .uv_out_din(uv_out_din), .uv_out_full_n(uv_out_full_n), .uv_out_write(uv_out_write),
        .dbg_state(dbg_state)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        int          rows;
        int          cols;
        bit          stall;
        logic [15:0] base;
    } vec_t;

    vec_t        vecs [6];
    logic [15:0] in_q [$];
    logic [15:0] exp_q [$];
    logic [15:0] got_q [$];
    bit          param_v, stall_en;
    int          n_wr, n_ready, n_rowpop, n_viol;
    int          checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic drive();
        uv_in_empty_n = (in_q.size() > 0);
        uv_in_dout    = (in_q.size() > 0) ? in_q[0] : 16'h0;
        rows_empty_n  = param_v;
        cols_empty_n  = param_v;
        uv_out_full_n = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    // One clock: sample strobes mid-cycle, let the edge happen, then update the FIFO models.
    task automatic tick();
        bit pop_in, pop_par;
        @(negedge ap_clk);
        if (uv_out_write) begin
            got_q.push_back(uv_out_din);
            n_wr++;
        end
        if (uv_out_write && !uv_out_full_n) n_viol++;
        if (uv_in_read && !uv_in_empty_n) n_viol++;
        if (rows_read !== cols_read) n_viol++;
        if (ap_ready) n_ready++;
        pop_in  = uv_in_read;
        pop_par = rows_read;
        @(posedge ap_clk);
        #1;
        if (pop_in && in_q.size() > 0) void'(in_q.pop_front());
        if (pop_par) begin
            param_v = 1'b0;
            n_rowpop++;
        end
        drive();
    endtask

    task automatic setup_frame(input int rows, input int cols, input bit stall, input logic [15:0] base);
        int n_in;
        in_q.delete();
        exp_q.delete();
        got_q.delete();
        n_wr = 0; n_ready = 0; n_rowpop = 0; n_viol = 0;
        n_in = (rows == 0 || cols == 0) ? 8 : rows * cols;
        for (int i = 0; i < n_in; i++) in_q.push_back(base + 16'(i));
        for (int r = 0; r < rows; r++)
            for (int p = 0; p < 2; p++)
                for (int c = 0; c < cols; c++) exp_q.push_back(base + 16'(r * cols + c));
        rows_dout = 11'(rows);
        cols_dout = 11'(cols);
        param_v   = 1'b1;
        stall_en  = stall;
        drive();
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
    endtask

    task automatic run_frame(input int rows, input int cols, input bit stall,
                             input logic [15:0] base, input int hold);
        int cyc = 0;
        int leftover;
        setup_frame(rows, cols, stall, base);
        leftover = (rows == 0 || cols == 0) ? 8 : 0;
        while (!ap_done && cyc < 4000) begin
            tick();
            cyc++;
        end
        chk($sformatf("done_r%0dc%0d", rows, cols), ap_done, 1);
        if (leftover != 0) chk($sformatf("done_latency_r%0dc%0d", rows, cols), 32'(cyc <= 3), 1);
        if (hold > 0) begin
            ap_start  = 1'b1;
            param_v   = 1'b1;
            drive();
            for (int k = 0; k < hold; k++) begin
                tick();
                chk($sformatf("hold_done_%0d", k), ap_done, 1);
            end
            chk("hold_no_param_pop", n_rowpop, 1);
            ap_start = 1'b0;
            param_v  = 1'b0;
            drive();
        end
        ap_continue = 1'b1;
        tick();
        ap_continue = 1'b0;
        chk($sformatf("idle_after_cont_r%0dc%0d", rows, cols), ap_idle, 1);
        chk($sformatf("nwr_r%0dc%0d", rows, cols), n_wr, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("pix_r%0dc%0d_%0d", rows, cols, i),
                (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
        chk($sformatf("ready_pulses_r%0dc%0d", rows, cols), n_ready, 1);
        chk($sformatf("param_pops_r%0dc%0d", rows, cols), n_rowpop, 1);
        chk($sformatf("in_left_r%0dc%0d", rows, cols), in_q.size(), leftover);
        chk($sformatf("protocol_r%0dc%0d", rows, cols), n_viol, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_idle"}, ap_idle, 1);
        chk({tag, "_done"}, ap_done, 0);
        chk({tag, "_ready"}, ap_ready, 0);
        chk({tag, "_rows_read"}, rows_read, 0);
        chk({tag, "_cols_read"}, cols_read, 0);
        chk({tag, "_in_read"}, uv_in_read, 0);
        chk({tag, "_out_write"}, uv_out_write, 0);
        chk({tag, "_out_din"}, uv_out_din, 0);
        chk({tag, "_state"}, dbg_state, ST_IDLE);
    endtask

    initial begin
        int cyc;
        vecs[0] = '{rows: 2, cols: 4, stall: 1'b0, base: 16'h0001};
        vecs[1] = '{rows: 1, cols: 1, stall: 1'b0, base: 16'hABCD};
        vecs[2] = '{rows: 3, cols: 5, stall: 1'b1, base: 16'h0200};
        vecs[3] = '{rows: 0, cols: 8, stall: 1'b0, base: 16'h0300};
        vecs[4] = '{rows: 4, cols: 0, stall: 1'b0, base: 16'h0400};
        vecs[5] = '{rows: 2, cols: 3, stall: 1'b1, base: 16'h0500};

        param_v  = 1'b0;
        stall_en = 1'b0;
        #2;
        check_reset_outputs("por");
        repeat (3) @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        drive();
        tick();

        for (int v = 0; v < 6; v++) run_frame(vecs[v].rows, vecs[v].cols, vecs[v].stall, vecs[v].base, 0);

        // Continue held low for 10 cycles with a start request pending, then a normal frame.
        run_frame(1, 3, 1'b0, 16'h0600, 10);
        run_frame(2, 2, 1'b0, 16'h0700, 0);

        // Reset pulsed in the middle of a row replay.
        setup_frame(2, 4, 1'b0, 16'h0800);
        cyc = 0;
        while (dbg_state != ST_PASS1 && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("reach_pass1", dbg_state, ST_PASS1);
        tick();
        ap_rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        in_q.delete();
        param_v  = 1'b0;
        stall_en = 1'b0;
        drive();
        repeat (2) @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        drive();
        run_frame(1, 2, 1'b0, 16'h0055, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pp_pipeline_accel_uv_row_dup.md
PP_PIPELINE_ACCEL_UV_ROW_DUP -- requirements
Module: pp_pipeline_accel_uv_row_dup

Interface
REQ-001 Clocking and reset SHALL be one clock and an asynchronous, active-low reset: ap_clk and ap_rst_n.
REQ-002 Parameter PIX_W, default 16, SHALL set the bit width of one packed UV pixel.
REQ-003 Parameter DIM_W, default 11, SHALL set the bit width of the rows and cols values.
REQ-004 Parameter MAX_COLS, default 2048, SHALL set the line-buffer depth in pixels.
REQ-005 ap_clk  in  1  clock.
REQ-006 ap_rst_n  in  1  async active-low reset.
REQ-007 ap_start / ap_done / ap_ready / ap_idle / ap_continue  in/out/out/out/in  1 each  block-level handshake.
REQ-008 rows_dout  in  DIM_W  UV-plane row count; rows_empty_n in 1 (data available); rows_read out 1 (pop).
REQ-009 cols_dout  in  DIM_W  UV-plane pixels per row; cols_empty_n in 1; cols_read out 1.
REQ-010 uv_in_dout  in  PIX_W  UV pixel from the AxiStream2Mat stage; uv_in_empty_n in 1; uv_in_read out 1.
REQ-011 uv_out_din  out  PIX_W  output pixel; uv_out_full_n in 1 (space available); uv_out_write out 1.

Function
REQ-012 The block SHALL convert 4:2:0 chroma to 4:2:2 by emitting every input UV row twice, consecutively: 2*rows output rows of cols pixels each.
REQ-013 FSM states SHALL be IDLE, PARAM, PASS0, PASS1 and DONE.
REQ-014 IDLE SHALL go to PARAM when ap_start=1; ap_idle SHALL be 1 only in IDLE.
REQ-015 PARAM SHALL pop rows and cols in one cycle, with rows_read=cols_read=1, only when both *_empty_n=1, and SHALL latch both values.
REQ-016 If the latched rows=0 or cols=0, PARAM SHALL go directly to DONE and emit no pixels.
REQ-017 In PASS0, a transfer SHALL occur only in a cycle with uv_in_empty_n=1 and uv_out_full_n=1; that cycle SHALL assert uv_in_read and uv_out_write together, forward uv_in_dout unchanged, and write it to line-buffer address col.
REQ-018 In PASS1, the block SHALL replay line-buffer addresses 0..cols-1 in order, SHALL NOT read uv_in, and SHALL write only when uv_out_full_n=1.
REQ-019 The line-buffer read latency is 1 cycle; PASS1 SHALL use a one-entry prefetch/skid register so that output throughput is one pixel per cycle while uv_out_full_n=1, with no bubble at the PASS0->PASS1 boundary beyond one cycle.
REQ-020 A stall (uv_out_full_n=0) SHALL hold uv_out_din stable and lose or duplicate no pixel.
REQ-021 The column counter SHALL wrap to 0 at cols-1; PASS0 SHALL go to PASS1 on the last column, and PASS1 SHALL go to PASS0 on the last column.
REQ-022 After the last column of PASS1 on row rows-1, the FSM SHALL go to DONE.
REQ-023 In DONE, ap_done SHALL be held at 1 until ap_continue=1; ap_ready SHALL pulse for 1 cycle on DONE entry; ap_done and ap_continue high together SHALL return the FSM to IDLE.
REQ-024 A new ap_start SHALL be ignored outside IDLE.
REQ-025 Counters SHALL be DIM_W bits wide; cols > MAX_COLS is outside the specified range (no check required).

Reset
REQ-026 With ap_rst_n=0, the FSM SHALL be in IDLE, counters 0, and the skid register invalid.
REQ-027 Reset values: ap_idle=1; ap_done, ap_ready, rows_read, cols_read, uv_in_read and uv_out_write =0; uv_out_din=0.
REQ-028 Reset asserted mid-frame SHALL abort immediately with no further FIFO pops or writes; line-buffer contents are don't-care.

Structure
REQ-029 A shared package pp_uv_pkg SHALL hold the FSM state enum and the PIX_W, DIM_W and MAX_COLS defaults.
REQ-030 The line buffer SHALL be the sub-module pp_pipeline_accel_uv_linebuf: a simple dual-port RAM, 1 write port and 1 read port, 1-cycle registered read.

Verification
REQ-031 rows=2, cols=4, input 0x0001..0x0008, sink always ready -> output 0x0001-0x0004 x2, then 0x0005-0x0008 x2; 16 writes; ap_done asserted.
REQ-032 rows=0, cols=8 -> no uv_in_read, no uv_out_write; ap_done within 3 cycles of the parameter pop.
REQ-033 rows=1, cols=1, input 0xABCD -> exactly two writes of 0xABCD.
REQ-034 rows=3, cols=5, sink drops uv_out_full_n randomly at 50% -> output sequence identical to the no-stall reference; count 30.
REQ-035 ap_continue held 0 for 10 cycles after done -> ap_done stays 1 throughout, ap_start ignored; the next frame starts only after ap_continue=1.
REQ-036 ap_rst_n pulsed low mid-PASS1 -> all outputs at reset values in the same cycle; a following rows=1, cols=2 frame completes correctly.
